prpg_checker: RTL and testbench
===============================

# prpg_checker

Receive-side companion to the on-chip 3-bit pseudo-random pattern generator. It accepts the generator's 3-bit pattern words, self-synchronises a local predictor to the stream, and then flags and counts every word that deviates from the predicted sequence. It sits at the sink end of a BIST or link-test path, where the generator drives the path under test.

## Interface
- LOCK_CNT, default 4: consecutive in-sequence valid words required to declare lock; legal range 2..15.
- LOSS_CNT, default 3: consecutive mismatching valid words in LOCKED that force loss of lock; legal range 1..15.
- ERR_W, default 16: width of the error counter.

Ports:
- clk  in  1  sole clock, rising edge.
- clr_n  in  1  synchronous active-low reset.
- din_valid  in  1  qualifies din for this cycle.
- din  in  [3:1]  received pattern word.
- err_clr  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatching word in LOCKED.
- sync_loss  out  1  one-cycle pulse on the LOCKED→HUNT transition.
- err_count  out  [ERR_W-1:0]  saturating mismatch count.
- expected  out  [3:1]  predictor value, i.e. the word expected on the next valid cycle.

## Operation
- Sequence function: nxt(s) = {s[2:1], s[3]^s[1]}. This gives period 7 over the nonzero states: 001→011→111→110→101→010→100→001. 000 is illegal.
- Internal state is FSM {HUNT, LOCKED}, plus pred[3:1], match_cnt, and miss_cnt.
- A cycle with din_valid=0 changes no state, counter, or pred. All outputs hold, except that the pulses deassert.
- HUNT, valid word w:
  - If w=000: match_cnt←0 and pred is unchanged.
  - Else if match_cnt>0 and w=pred: match_cnt←match_cnt+1 and pred←nxt(w).
  - Else (a fresh seed): match_cnt←1 and pred←nxt(w).
  - When the updated match_cnt equals LOCK_CNT: go to LOCKED, miss_cnt←0.
  - Mismatches in HUNT are never counted.
- LOCKED, valid word w (flywheel mode, with no reseeding):
  - pred←nxt(pred) on every valid word, matching or not.
  - If w=pred: miss_cnt←0.
  - Else: err_pulse, err_count increments and saturates at 2^ERR_W−1, miss_cnt increments. 000 counts as a mismatch.
  - When the updated miss_cnt equals LOSS_CNT: go to HUNT, match_cnt←0, and pulse sync_loss. The word that triggers the transition is still counted as an error.
- err_clr:
  - err_count←0.
  - If an error is counted in the same cycle, err_count←1.
  - err_clr does not affect the FSM.
- clr_n=0 takes priority over every other input, including mid-lock and mid-hunt.

## Timing
- All outputs are registered and update on the rising clk edge after the accepted word.
- Latency is one cycle from the valid word to err_pulse, sync_loss, locked, and the err_count update.
- Reset values, applied on the first edge with clr_n=0:
  - locked=0, err_pulse=0, sync_loss=0, err_count=0.
  - expected=001, FSM=HUNT, match_cnt=0, miss_cnt=0.
- locked rises on the edge that accepts the LOCK_CNT-th in-sequence word.
- locked falls in the same cycle that sync_loss pulses.
- err_pulse and sync_loss never stay high for two cycles from a single word.
- Throughput is one word per clock, with no back-pressure.
- Simultaneous events:
  - Error plus saturation: err_count holds at its maximum and err_pulse still fires.
  - Error plus loss of lock: err_pulse and sync_loss fire together.

## Test plan
- Release reset, then feed the continuous sequence 001,011,111,110,… → locked=1 after the edge accepting 110; 20 further words → err_count=0, no pulses.
- Lock, then replace one 101 with 100 → err_pulse for one cycle, err_count=1, locked stays 1; the following 010 matches.
- Lock, then send 3 consecutive wrong words → err_count=3, sync_loss and locked falling on the 3rd; resume a correct stream from 011 → relock after 4 words.
- In HUNT, send 000 repeatedly, then an out-of-order stream 001,111,001,111 → locked never rises and err_count stays 0.
- Lock with din_valid toggling 1/0, then a valid gap of 5 cycles, then the sequence continued → no errors and expected unchanged across the gap; clr_n low for one cycle mid-lock → locked=0, err_count=0, expected=001 next cycle.
- ERR_W=2, alternate good and bad words while locked → err_count saturates at 3; err_clr together with a bad word → err_count=1.

Source files
------------

// File: rtl/prpg_checker.sv
// prpg_checker: receive-side checker for the 3-bit pseudo-random pattern
// generator. It hunts for a run of in-sequence words to seed its predictor,
// then flywheels through the sequence while locked, flagging and counting
// every deviation until too many consecutive misses drop it back to hunt.
module prpg_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             din_valid,
  input  logic [3:1]       din,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_loss,
  output logic [ERR_W-1:0] err_count,
  output logic [3:1]       expected
);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
  localparam logic [3:0]       LOSS_C  = 4'(LOSS_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [0:0]       state_q, state_d;
  logic [3:1]       pred_q, pred_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             sync_loss_q, sync_loss_d;
  logic             err_event;

  function automatic logic [3:1] nxt(input logic [3:1] s);
    return {s[2:1], s[3] ^ s[1]};
  endfunction

  // Next-state logic: hunt/lock FSM, predictor, run counters and pulses.
  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    sync_loss_d = 1'b0;
    err_event   = 1'b0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (din == 3'b000) begin
          match_d = '0;
        end else if (match_q != '0 && din == pred_q) begin
          match_d = match_q + 4'd1;
          pred_d  = nxt(din);
        end else begin
          match_d = 4'd1;
          pred_d  = nxt(din);
        end
        if (match_d == LOCK_C) begin
          state_d = LOCKED;
          miss_d  = '0;
        end
      end else begin
        // Flywheel: the predictor free-runs, a received word never reseeds it.
        pred_d = nxt(pred_q);
        if (din == pred_q) begin
          miss_d = '0;
        end else begin
          err_event   = 1'b1;
          err_pulse_d = 1'b1;
          miss_d      = miss_q + 4'd1;
          if (miss_d == LOSS_C) begin
            state_d     = HUNT;
            match_d     = '0;
            sync_loss_d = 1'b1;
          end
        end
      end
    end
  end

  // Error counter: clear wins over hold, but a same-cycle error leaves one.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = err_event ? ERR_W'(1) : '0;
    end else if (err_event && cnt_q != ERR_MAX) begin
      cnt_d = cnt_q + ERR_W'(1);
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q     <= HUNT;
      pred_q      <= 3'b001;
      match_q     <= '0;
      miss_q      <= '0;
      cnt_q       <= '0;
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      cnt_q       <= cnt_d;
      err_pulse_q <= err_pulse_d;
      sync_loss_q <= sync_loss_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign sync_loss = sync_loss_q;
  assign err_count = cnt_q;
  assign expected  = pred_q;

endmodule

// File: tb/tb_prpg_checker.sv
// Directed bench for prpg_checker: a default instance plus an ERR_W=2
// instance sharing the same stimulus for the saturation checks.
module tb_prpg_checker;

  logic        clk = 1'b0;
  logic        clr_n, din_valid, err_clr;
  logic [3:1]  din;
  logic        locked, err_pulse, sync_loss;
  logic [15:0] err_count;
  logic [3:1]  expected;
  logic        locked2, err_pulse2, sync_loss2;
  logic [1:0]  err_count2;
  logic [3:1]  expected2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:1] seq [7] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b101, 3'b010, 3'b100};
  int p;

  always #5 clk = ~clk;

  prpg_checker dut (
    .clk(clk), .clr_n(clr_n), .din_valid(din_valid), .din(din), .err_clr(err_clr),
    .locked(locked), .err_pulse(err_pulse), .sync_loss(sync_loss),
    .err_count(err_count), .expected(expected)
  );

  prpg_checker #(.ERR_W(2)) dut2 (
    .clk(clk), .clr_n(clr_n), .din_valid(din_valid), .din(din), .err_clr(err_clr),
    .locked(locked2), .err_pulse(err_pulse2), .sync_loss(sync_loss2),
    .err_count(err_count2), .expected(expected2)
  );

  task automatic step(input logic rst_n, input logic v, input logic [3:1] w, input logic ec);
    clr_n = rst_n; din_valid = v; din = w; err_clr = ec;
    @(posedge clk);
    #1;
    clr_n = 1'b1; din_valid = 1'b0; din = 3'b000; err_clr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic good();
    step(1'b1, 1'b1, seq[p], 1'b0);
    p = (p + 1) % 7;
  endtask

  initial begin
    clr_n = 1'b1; din_valid = 1'b0; din = 3'b000; err_clr = 1'b0;
    #2;

    // Reset state
    step(1'b0, 1'b1, 3'b101, 1'b1);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_pulse", 32'(err_pulse), 0);
    chk("rst_sync_loss", 32'(sync_loss), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_expected", 32'(expected), 32'h1);

    // Acquire lock on the 4th in-sequence word
    p = 0;
    for (int i = 0; i < 3; i++) begin
      good();
      chk("acq_unlocked", 32'(locked), 0);
    end
    good();
    chk("acq_locked", 32'(locked), 1);
    chk("acq_expected", 32'(expected), 32'h5);
    for (int i = 0; i < 20; i++) begin
      good();
      chk("run_no_err_pulse", 32'(err_pulse), 0);
      chk("run_no_sync_loss", 32'(sync_loss), 0);
    end
    chk("run_err_count", 32'(err_count), 0);
    chk("run_locked", 32'(locked), 1);
    chk("run_expected", 32'(expected), 32'h6);

    // Single substituted word: 100 in place of 101
    good();
    step(1'b1, 1'b1, 3'b100, 1'b0);
    chk("sub_err_pulse", 32'(err_pulse), 1);
    chk("sub_err_count", 32'(err_count), 1);
    chk("sub_locked", 32'(locked), 1);
    chk("sub_expected", 32'(expected), 32'h2);
    step(1'b1, 1'b1, 3'b010, 1'b0);
    chk("sub_next_pulse", 32'(err_pulse), 0);
    chk("sub_next_count", 32'(err_count), 1);
    chk("sub_next_locked", 32'(locked), 1);

    // Clear the counter on an idle cycle, then three misses lose lock
    step(1'b1, 1'b0, 3'b000, 1'b1);
    chk("clr_idle_count", 32'(err_count), 0);
    chk("clr_idle_locked", 32'(locked), 1);
    step(1'b1, 1'b1, 3'b000, 1'b0);
    chk("loss1_pulse", 32'(err_pulse), 1);
    chk("loss1_sync", 32'(sync_loss), 0);
    chk("loss1_locked", 32'(locked), 1);
    step(1'b1, 1'b1, 3'b000, 1'b0);
    chk("loss2_count", 32'(err_count), 2);
    chk("loss2_locked", 32'(locked), 1);
    step(1'b1, 1'b1, 3'b000, 1'b0);
    chk("loss3_count", 32'(err_count), 3);
    chk("loss3_pulse", 32'(err_pulse), 1);
    chk("loss3_sync", 32'(sync_loss), 1);
    chk("loss3_locked", 32'(locked), 0);
    chk("loss3_expected", 32'(expected), 32'h7);

    // Relock from 011
    p = 1;
    good();
    chk("relock1_sync", 32'(sync_loss), 0);
    chk("relock1_pulse", 32'(err_pulse), 0);
    chk("relock1_locked", 32'(locked), 0);
    good();
    good();
    chk("relock3_locked", 32'(locked), 0);
    good();
    chk("relock4_locked", 32'(locked), 1);
    chk("relock_count", 32'(err_count), 3);

    // Hunt with zeros and an out-of-order stream never locks
    step(1'b0, 1'b0, 3'b000, 1'b0);
    chk("hunt_rst_locked", 32'(locked), 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 3'b000, 1'b0);
      chk("hunt_zero_expected", 32'(expected), 32'h1);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 3'b001, 1'b0);
      chk("hunt_ooo_locked", 32'(locked), 0);
      step(1'b1, 1'b1, 3'b111, 1'b0);
      chk("hunt_ooo_locked", 32'(locked), 0);
      chk("hunt_ooo_count", 32'(err_count), 0);
      chk("hunt_ooo_pulse", 32'(err_pulse), 0);
    end
    chk("hunt_ooo_expected", 32'(expected), 32'h6);

    // Lock with valid toggling, then a 5-cycle gap
    step(1'b0, 1'b0, 3'b000, 1'b0);
    p = 0;
    for (int i = 0; i < 4; i++) begin
      good();
      step(1'b1, 1'b0, 3'b010, 1'b0);
    end
    chk("gap_locked", 32'(locked), 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 3'b000, 1'b0);
      chk("gap_expected", 32'(expected), 32'h5);
      chk("gap_pulse", 32'(err_pulse), 0);
    end
    for (int i = 0; i < 3; i++) good();
    chk("gap_resume_count", 32'(err_count), 0);
    chk("gap_resume_expected", 32'(expected), 32'h1);
    step(1'b1, 1'b1, 3'b000, 1'b0);
    chk("pre_rst_count", 32'(err_count), 1);
    step(1'b0, 1'b1, 3'b011, 1'b0);
    chk("midlock_rst_locked", 32'(locked), 0);
    chk("midlock_rst_count", 32'(err_count), 0);
    chk("midlock_rst_expected", 32'(expected), 32'h1);
    chk("midlock_rst_pulse", 32'(err_pulse), 0);

    // ERR_W=2 saturation and clear-with-error
    p = 0;
    for (int i = 0; i < 4; i++) good();
    chk("sat_locked", 32'(locked2), 1);
    for (int i = 0; i < 3; i++) begin
      good();
      step(1'b1, 1'b1, 3'b000, 1'b0);
      p = (p + 1) % 7;
      chk("sat_count_climb", 32'(err_count2), 32'(i + 1));
    end
    good();
    step(1'b1, 1'b1, 3'b000, 1'b0);
    p = (p + 1) % 7;
    chk("sat_count_hold", 32'(err_count2), 3);
    chk("sat_pulse", 32'(err_pulse2), 1);
    chk("sat_wide_count", 32'(err_count), 4);
    good();
    step(1'b1, 1'b1, 3'b000, 1'b1);
    chk("sat_clr_err_count", 32'(err_count2), 1);
    chk("sat_clr_err_pulse", 32'(err_pulse2), 1);
    chk("sat_clr_locked", 32'(locked2), 1);
    chk("sat_clr_wide_count", 32'(err_count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
